// File: rtl/inst_fetch_pkg.sv
// Shared constants for the instruction fetch stage (bus widths, chip-enable levels, instruction size).
// The optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
package inst_fetch_pkg;

   localparam int unsigned INST_ADDR_W  = 64;       // `InstAddrBus
   localparam int unsigned INST_DATA_W  = 64;       // `InstBus
   localparam logic        CHIP_ENABLE  = 1'b1;     // `ChipEnable
   localparam logic        CHIP_DISABLE = 1'b0;     // `ChipDisable
   localparam logic [63:0] ZERO_DWORD   = 64'h0;    // `ZeroDoubleWord
   localparam int unsigned INST_BYTES   = 8;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-to-decode handshake: {pc,inst} head entry offered with valid, taken with ready.
interface inst_fetch_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned INST_W = 64
);
   logic              id_valid;
   logic              id_ready;
   logic [ADDR_W-1:0] id_pc;
   logic [INST_W-1:0] id_inst;

   modport master (output id_valid, output id_pc, output id_inst, input id_ready);
   modport slave  (input id_valid, input id_pc, input id_inst, output id_ready);
endinterface

// File: rtl/inst_fetch_buf.sv
// Two-entry FIFO of {pc,inst} pairs with synchronous clear; head outputs read zero when empty.
module inst_fetch_buf #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned INST_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_pc,
   input  logic [INST_W-1:0] push_inst,
   output logic [1:0]        count,
   output logic              head_valid,
   output logic [ADDR_W-1:0] head_pc,
   output logic [INST_W-1:0] head_inst
);

   logic [ADDR_W-1:0] pc_mem   [2];
   logic [INST_W-1:0] inst_mem [2];
   logic              rd_ptr;
   logic              wr_ptr;

   // Push into a full buffer is only legal alongside a pop; the slot written is the one leaving.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         count       <= 2'd0;
         pc_mem[0]   <= '0;
         pc_mem[1]   <= '0;
         inst_mem[0] <= '0;
         inst_mem[1] <= '0;
      end else if (clear) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head_valid = (count != 2'd0);
   assign head_pc    = head_valid ? pc_mem[rd_ptr]   : '0;
   assign head_inst  = head_valid ? inst_mem[rd_ptr] : '0;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, drives the ROM, buffers {pc,inst} for decode, handles flush/branch redirects.
// Define FETCH_PERF_CNT_EN to add saturating perf_fetched / perf_stall counters.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int unsigned            ADDR_W   = INST_ADDR_W,
   parameter int unsigned            INST_W   = INST_DATA_W,
   parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              rom_ce,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [INST_W-1:0] rom_inst,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] flush_pc,
   input  logic              br_valid,
   input  logic [ADDR_W-1:0] br_target,
   inst_fetch_if.master      id
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_stall
`endif
);

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INST_BYTES - 1);

   logic              ce_q;
   logic [ADDR_W-1:0] pc;
   logic [1:0]        count;
   logic              pop;
   logic              redirect;
   logic              fetch_fire;
   logic              head_valid;

   assign pop        = id.id_valid & id.id_ready;
   assign redirect   = flush_i | br_valid;
   assign fetch_fire = ce_q & ~stall_i & ~redirect & ((count < 2'd2) | pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         ce_q <= CHIP_DISABLE;
      else
         ce_q <= CHIP_ENABLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         pc <= RESET_PC;
      else if (flush_i)
         pc <= flush_pc & ALIGN_MASK;
      else if (br_valid)
         pc <= br_target & ALIGN_MASK;
      else if (fetch_fire)
         pc <= pc + ADDR_W'(INST_BYTES);
   end

   assign rom_ce   = ce_q;
   assign rom_addr = pc;

   // The clear wins inside the buffer, so a pop during a redirect is discarded.
   inst_fetch_buf #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W)
   ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .clear      (redirect),
      .push       (fetch_fire),
      .pop        (pop),
      .push_pc    (pc),
      .push_inst  (rom_inst),
      .count      (count),
      .head_valid (head_valid),
      .head_pc    (id.id_pc),
      .head_inst  (id.id_inst)
   );

   assign id.id_valid = head_valid;

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (fetch_fire && (perf_fetched != '1))
            perf_fetched <= perf_fetched + 32'd1;
         if (ce_q && !fetch_fire && (perf_stall != '1))
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, streaming, back-pressure, redirects, stall, PC wrap, async reset.
module tb_inst_fetch;

   logic        clk;
   logic        rst;
   logic        rom_ce;
   logic [63:0] rom_addr;
   logic [63:0] rom_inst;
   logic        stall_i;
   logic        flush_i;
   logic [63:0] flush_pc;
   logic        br_valid;
   logic [63:0] br_target;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
`endif

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   inst_fetch_if #(.ADDR_W(64), .INST_W(64)) ifc ();

   inst_fetch #(
      .ADDR_W   (64),
      .INST_W   (64),
      .RESET_PC (64'h0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rom_ce    (rom_ce),
      .rom_addr  (rom_addr),
      .rom_inst  (rom_inst),
      .stall_i   (stall_i),
      .flush_i   (flush_i),
      .flush_pc  (flush_pc),
      .br_valid  (br_valid),
      .br_target (br_target),
      .id        (ifc)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_stall   (perf_stall)
`endif
   );

   // ROM model: a distinct word per address.
   function automatic logic [63:0] rom_word(input logic [63:0] a);
      return {a[31:0] ^ 32'hA5A5A5A5, ~a[31:0]};
   endfunction

   assign rom_inst = rom_word(rom_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_head(input string tag, input logic [63:0] pc);
      chk({tag, ".valid"}, {63'd0, ifc.id_valid}, 64'd1);
      chk({tag, ".pc"},    ifc.id_pc, pc);
      chk({tag, ".inst"},  ifc.id_inst, rom_word(pc));
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, ".valid"}, {63'd0, ifc.id_valid}, 64'd0);
      chk({tag, ".pc"},    ifc.id_pc, 64'd0);
      chk({tag, ".inst"},  ifc.id_inst, 64'd0);
   endtask

   initial begin
      rst          = 1'b0;
      stall_i      = 1'b0;
      flush_i      = 1'b0;
      flush_pc     = '0;
      br_valid     = 1'b0;
      br_target    = '0;
      ifc.id_ready = 1'b1;

      #2;
      chk("rst.rom_ce",   {63'd0, rom_ce}, 64'd0);
      chk("rst.rom_addr", rom_addr, 64'd0);
      chk_empty("rst");
      step();
      step();
      rst = 1'b1;
      #1;
      chk("rel.rom_ce", {63'd0, rom_ce}, 64'd0);

      // 1: streaming with ready high
      step();
      chk("t1.rom_ce",   {63'd0, rom_ce}, 64'd1);
      chk("t1.rom_addr", rom_addr, 64'd0);
      chk_empty("t1.e1");
      step();
      chk_head("t1.pc0", 64'd0);
      chk("t1.addr8", rom_addr, 64'd8);
      step();
      chk_head("t1.pc8", 64'd8);
      step();
      chk_head("t1.pc16", 64'd16);

      // 2: restart at 0 via flush, then back-pressure for 5 cycles
      flush_i      = 1'b1;
      flush_pc     = 64'h0;
      ifc.id_ready = 1'b0;
      step();
      flush_i = 1'b0;
      chk_empty("t2.flush");
      chk("t2.addr0", rom_addr, 64'd0);
      step();
      chk_head("t2.fill1", 64'd0);
      step();
      chk_head("t2.fill2", 64'd0);
      chk("t2.addr16a", rom_addr, 64'd16);
      step();
      step();
      step();
      chk_head("t2.held", 64'd0);
      chk("t2.addr16b", rom_addr, 64'd16);
`ifdef FETCH_PERF_CNT_EN
      chk("t2.perf_fetched", {32'd0, perf_fetched}, 64'd5);
      chk("t2.perf_stall",   {32'd0, perf_stall},   64'd4);
`endif
      ifc.id_ready = 1'b1;
      step();
      chk_head("t2.pc8", 64'd8);
      step();
      chk_head("t2.pc16", 64'd16);
      step();
      chk_head("t2.pc24", 64'd24);

      // 3: branch while full
      ifc.id_ready = 1'b0;
      step();
      chk_head("t3.full", 64'd24);
      chk("t3.addr", rom_addr, 64'd40);
      br_valid  = 1'b1;
      br_target = 64'h40;
      step();
      br_valid     = 1'b0;
      ifc.id_ready = 1'b1;
      chk_empty("t3.br");
      chk("t3.addr40", rom_addr, 64'h40);
      step();
      chk_head("t3.pc40", 64'h40);
      step();
      chk_head("t3.pc48", 64'h48);

      // 4: flush beats branch
      flush_i   = 1'b1;
      flush_pc  = 64'h100;
      br_valid  = 1'b1;
      br_target = 64'h40;
      step();
      flush_i  = 1'b0;
      br_valid = 1'b0;
      chk_empty("t4.redir");
      chk("t4.addr", rom_addr, 64'h100);
      step();
      chk_head("t4.pc100", 64'h100);

      // 5: stall drains the buffer and holds pc
      stall_i = 1'b1;
      step();
      chk_empty("t5.s1");
      chk("t5.addr1", rom_addr, 64'h108);
      step();
      step();
      chk_empty("t5.s3");
      chk("t5.addr3", rom_addr, 64'h108);
      stall_i = 1'b0;
      step();
      chk_head("t5.pc108", 64'h108);
      step();
      chk_head("t5.pc110", 64'h110);

      // 6: wrap at top of address space, then unaligned branch target
      br_valid  = 1'b1;
      br_target = 64'hFFFF_FFFF_FFFF_FFF8;
      step();
      br_valid = 1'b0;
      chk("t6.addr_top", rom_addr, 64'hFFFF_FFFF_FFFF_FFF8);
      step();
      chk_head("t6.pc_top", 64'hFFFF_FFFF_FFFF_FFF8);
      chk("t6.addr_wrap", rom_addr, 64'd0);
      step();
      chk_head("t6.pc0", 64'd0);
      br_valid  = 1'b1;
      br_target = 64'h45;
      step();
      br_valid = 1'b0;
      chk("t6.addr_align", rom_addr, 64'h40);
      step();
      chk_head("t6.pc_align", 64'h40);

      // async reset mid-cycle
      #3;
      rst = 1'b0;
      #1;
      chk("arst.rom_ce",   {63'd0, rom_ce}, 64'd0);
      chk("arst.rom_addr", rom_addr, 64'd0);
      chk_empty("arst");
`ifdef FETCH_PERF_CNT_EN
      chk("arst.perf_fetched", {32'd0, perf_fetched}, 64'd0);
      chk("arst.perf_stall",   {32'd0, perf_stall},   64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
